uart_tx_framed: RTL and testbench

//  Parametrised UART transmitter: next generation of the fixed 8-bit transmitter.
//  - Adds configurable data width, a runtime parity mode (none/even/odd) and 1 or 2 stop bits.
//  - Adds an internal divider, so no external baud clock is needed.
//  - Adds a valid/ready input handshake backed by a small FIFO.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_fifo.sv | 75 +++++++
 rtl/uart_tx_framed.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_framed.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: parity modes,
// transmit FSM encoding and parity helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Widest supported data word; parity is computed over a zero-extended copy.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Mode 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Even: bit makes the total count of ones even. Odd: total count odd.
  function automatic logic parity_bit(input logic [1:0] mode,
                                      input logic [MAX_DATA_BITS-1:0] data);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous input FIFO for the UART transmitter. Head word is visible on
// rdata while not empty; full and empty are registered from the next level.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty,
  output logic [LVL_W-1:0]     level
);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push_ok, pop_ok;

  // A push while full is dropped; a pop while empty is ignored.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  // Pointer, level and flag update for this cycle's push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_W'(FIFO_DEPTH));
    empty_d = (level_d == '0);
  end

  // Control state; reset discards contents by clearing pointers and level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: FIFO-buffered input, internal baud divider,
// runtime parity mode and 1/2 stop bits. Line output lags the FSM state by
// one cycle so every output comes straight from a flop.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   ST_IDLE   | line high, waiting for a word in the FIFO
//   ST_START  | start bit (low) for one bit time
//   ST_DATA   | DATA_BITS data bits, LSB first
//   ST_PARITY | parity bit, only when the frame config enables it
//   ST_STOP   | one or two stop bits (high), then next word or idle
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 serial_out
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop2_cfg_q, stop2_cfg_d;
  logic                 par_en_q, par_en_d;
  logic                 par_val_q, par_val_d;
  logic                 serial_out_q, serial_out_d;
  logic                 busy_q, busy_d;

  logic                 bit_done;
  logic                 load;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (load),
    .wdata (tx_data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_done = (baud_cnt_q == BAUD_LAST);

  // Next-state, counters and frame loading; a load pops the FIFO head and
  // freezes the config so mid-frame input changes only affect later frames.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = bit_done ? '0 : baud_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop2_cfg_d = stop2_cfg_q;
    par_en_d    = par_en_q;
    par_val_d   = par_val_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        load       = !fifo_empty;
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          if (stop2_cfg_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            load    = !fifo_empty;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Queued word goes straight from the last stop cycle into START.
    if (load) begin
      state_d     = ST_START;
      bit_cnt_d   = '0;
      shift_d     = fifo_rdata;
      stop2_cfg_d = stop2;
      par_en_d    = parity_enabled(parity_mode);
      par_val_d   = parity_bit(parity_mode, MAX_DATA_BITS'(fifo_rdata));
    end
  end

  // Line level and busy derived from the current state, registered below.
  always_comb begin
    case (state_q)
      ST_START:  serial_out_d = 1'b0;
      ST_DATA:   serial_out_d = shift_q[0];
      ST_PARITY: serial_out_d = par_val_q;
      default:   serial_out_d = 1'b1;
    endcase
    busy_d = (state_q != ST_IDLE) || !fifo_empty;
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      stop2_cfg_q  <= 1'b0;
      par_en_q     <= 1'b0;
      par_val_q    <= 1'b0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      stop2_cfg_q  <= stop2_cfg_d;
      par_en_q     <= par_en_d;
      par_val_q    <= par_val_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign tx_ready   = !fifo_full;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: directed timing checks plus a
// randomized phase, with a line monitor decoding frames against a model.
module tb_uart_tx_framed;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [DB-1:0] tx_data_in;
  logic [1:0]    parity_mode;
  logic          stop2;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic          serial_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] sb[$];
  int         starts[$];
  int         lens[$];
  logic       par_obs[$];

  // monitor state
  logic [2:0]  mon_cfg_now, mon_cfg_prev;
  logic        mon_rst;
  bit          mon_in_frame;
  int          mon_idx, mon_nb, mon_mism;
  logic [15:0] mon_bits;
  logic [7:0]  mon_w, mon_got_w;
  logic        mon_bit9;

  always #5 sys_clk = ~sys_clk;

  uart_tx_framed #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data_in  (tx_data_in),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .serial_out  (serial_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line bits of one frame, one entry per bit time; returns bit count.
  function automatic int model_frame(input logic [7:0] w, input logic [1:0] mode,
                                     input logic s2, output logic [15:0] bits);
    int n;
    int ones;
    ones = $countones(w);
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < DB; i++) begin
      bits[n] = w[i];
      n++;
    end
    if (mode == 2'b01) begin
      bits[n] = (ones % 2 == 1);
      n++;
    end else if (mode == 2'b10) begin
      bits[n] = (ones % 2 == 0);
      n++;
    end
    n += s2 ? 2 : 1;
    return n;
  endfunction

  // Line monitor: counts edges, samples the line after each edge and decodes
  // frames. The config of a frame is the one present at the edge before its
  // start bit appears (the pop edge).
  initial begin
    mon_cfg_prev = 3'b000;
    mon_in_frame = 0;
    mon_idx = 0;
    mon_nb = 0;
    mon_mism = 0;
    mon_bits = '1;
    mon_w = '0;
    mon_got_w = '0;
    mon_bit9 = 1'b1;
    forever begin
      @(posedge sys_clk);
      mon_cfg_now = {stop2, parity_mode};
      mon_rst = rst;
      #1;
      cyc++;
      if (mon_rst === 1'b1) begin
        mon_in_frame = 0;
      end else begin
        if (!mon_in_frame && serial_out === 1'b0) begin
          mon_in_frame = 1;
          mon_idx = 0;
          mon_mism = 0;
          mon_got_w = '0;
          mon_bit9 = 1'b1;
          check("frame_expected", 32'(sb.size() != 0), 1);
          mon_w = (sb.size() != 0) ? sb.pop_front() : 8'h00;
          mon_nb = model_frame(mon_w, mon_cfg_prev[1:0], mon_cfg_prev[2], mon_bits);
          starts.push_back(cyc);
          lens.push_back(mon_nb);
        end
        if (mon_in_frame) begin
          if (serial_out !== mon_bits[mon_idx / CPB]) mon_mism++;
          if (mon_idx % CPB == CPB / 2) begin
            if (mon_idx / CPB >= 1 && mon_idx / CPB <= DB)
              mon_got_w[mon_idx / CPB - 1] = serial_out;
            if (mon_idx / CPB == DB + 1) mon_bit9 = serial_out;
          end
          mon_idx++;
          if (mon_idx == mon_nb * CPB) begin
            check("frame_wave", 32'(mon_mism), 0);
            check("frame_word", 32'(mon_got_w), 32'(mon_w));
            par_obs.push_back(mon_bit9);
            mon_in_frame = 0;
          end
        end
      end
      mon_cfg_prev = mon_cfg_now;
    end
  end

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  // Holds tx_valid until accepted; returns the cycle index of the accept edge.
  task automatic push_word(input logic [7:0] w, output int acc);
    int n = 0;
    tx_valid = 1'b1;
    tx_data_in = w;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("push_accept", 32'(tx_ready), 1);
    if (tx_ready === 1'b1) sb.push_back(w);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(output int fall);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_reached", 32'(busy), 0);
    fall = cyc;
  endtask

  initial begin
    int n0, acc, fall, len3, base, nstarts, lows;
    logic [1:0] m3;
    logic [7:0] t2_word [3];
    logic [1:0] t2_mode [3];
    logic       t2_par  [3];
    t2_word = '{8'hCC, 8'hCD, 8'h01};
    t2_mode = '{2'b01, 2'b10, 2'b01};
    t2_par  = '{1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data_in = '0;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_serial", 32'(serial_out), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_level", 32'(fifo_level), 0);
    rst = 1'b0;
    @(negedge sys_clk);

    // 1: basic frame, no parity, one stop bit
    push_word(8'hAA, n0);
    check("t1_level_push", 32'(fifo_level), 1);
    check("t1_busy_n0", 32'(busy), 0);
    check("t1_serial_n0", 32'(serial_out), 1);
    @(negedge sys_clk);
    check("t1_busy_n1", 32'(busy), 1);
    check("t1_level_pop", 32'(fifo_level), 0);
    check("t1_serial_n1", 32'(serial_out), 1);
    @(negedge sys_clk);
    check("t1_serial_start", 32'(serial_out), 0);
    wait_idle(fall);
    check("t1_busy_fall", fall, n0 + 2 + 10 * CPB);
    check("t1_len", lens[lens.size() - 1], 10);

    // 2: parity modes
    for (int i = 0; i < 3; i++) begin
      parity_mode = t2_mode[i];
      push_word(t2_word[i], n0);
      wait_cyc(n0 + 2);
      wait_idle(fall);
      check("t2_len", lens[lens.size() - 1], 11);
      check("t2_parity", 32'(par_obs[par_obs.size() - 1]), 32'(t2_par[i]));
      check("t2_busy_fall", fall, n0 + 2 + 11 * CPB);
    end

    // 3: two stop bits, fill the FIFO while a frame is in flight
    stop2 = 1'b1;
    m3 = 2'($urandom_range(0, 3));
    parity_mode = m3;
    len3 = CPB * (1 + DB + ((m3 == 2'b01 || m3 == 2'b10) ? 1 : 0) + 2);
    push_word(8'($urandom), n0);
    push_word(8'($urandom), acc);
    check("t3_level_pushpop", 32'(fifo_level), 1);
    for (int k = 2; k <= 4; k++) begin
      push_word(8'($urandom), acc);
      check("t3_level_fill", 32'(fifo_level), 32'(k));
    end
    check("t3_ready_full", 32'(tx_ready), 0);
    push_word(8'($urandom), acc);
    check("t3_hold_accept", acc, n0 + 2 + len3);
    check("t3_level_refill", 32'(fifo_level), 4);
    wait_idle(fall);
    check("t3_busy_fall", fall, n0 + 2 + 6 * len3);
    base = starts.size() - 6;
    check("t3_first_start", starts[base], n0 + 2);
    for (int i = 0; i < 5; i++)
      check("t3_gap", starts[base + i + 1] - starts[base + i], len3);

    // 4: parity mode change during DATA only affects the next frame
    stop2 = 1'b0;
    parity_mode = 2'b00;
    push_word(8'h5A, n0);
    push_word(8'h3C, acc);
    wait_cyc(n0 + 2 + 10);
    parity_mode = 2'b10;
    wait_idle(fall);
    check("t4_len_cur", lens[lens.size() - 2], 10);
    check("t4_len_next", lens[lens.size() - 1], 11);
    check("t4_parity_next", 32'(par_obs[par_obs.size() - 1]), 1);
    check("t4_busy_fall", fall, n0 + 2 + 21 * CPB);

    // 5: reset during data bit 3 with two words queued
    parity_mode = 2'b00;
    push_word(8'($urandom), n0);
    push_word(8'($urandom), acc);
    push_word(8'($urandom), acc);
    wait_cyc(n0 + 2 + 17);
    check("t5_level_before", 32'(fifo_level), 2);
    rst = 1'b1;
    sb.delete();
    @(negedge sys_clk);
    check("t5_serial", 32'(serial_out), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_level", 32'(fifo_level), 0);
    check("t5_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    nstarts = starts.size();
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge sys_clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t5_quiet", lows, 0);
    check("t5_no_frames", starts.size(), nstarts);

    // 6: randomized traffic and config changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) parity_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) stop2 = 1'($urandom_range(0, 1));
      tx_valid = 1'($urandom_range(0, 1));
      tx_data_in = 8'($urandom);
      if (tx_valid && tx_ready === 1'b1) sb.push_back(tx_data_in);
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    wait_idle(fall);
    repeat (3) @(negedge sys_clk);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
